// File: rtl/axin_challoc_pkg.sv
// axin_challoc_pkg: shared beat widths, allocator state encoding and o_debug bit map.
package axin_challoc_pkg;
    localparam int AXIN_DW    = 64;
    localparam int AXIN_WBITS = $clog2(AXIN_DW / 8);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    // o_debug layout: [0] state, [DBG_ALLOC +: NIN] S_ALLOC,
    // [DBG_FLAGS +: 5] {midpkt, M_ABORT, M_LAST, M_READY, M_VALID}
    localparam int DBG_STATE = 0;
    localparam int DBG_ALLOC = 1;
    localparam int DBG_FLAGS = 16;
endpackage

// File: rtl/axin_rrpick.sv
// axin_rrpick: combinational round-robin pick of the first request at or after ptr_i.
// Ports: req_i request vector, ptr_i priority pointer, onehot_o/idx_o winner, any_o any request.
module axin_rrpick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Scan from farthest to nearest so the last hit is the closest to ptr_i.
    always_comb begin
        int j;
        j        = 0;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = IW'(j);
            end
        end
    end
endmodule

// File: rtl/axin_challoc.sv
// axin_challoc: per-egress channel allocator and registered stream multiplexer.
// Ports: i_clk/i_reset/i_cfg_active; S_* per-requester CHREQ/ALLOC and beat stream;
// M_* egress beat stream with ABORT; o_grant_idx current/last winner; o_debug status.
module axin_challoc
    import axin_challoc_pkg::*;
#(
    parameter int NIN          = 4,
    parameter int DW           = AXIN_DW,
    parameter int WBITS        = $clog2(DW / 8),
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cfg_active,
    input  logic [NIN-1:0]           S_CHREQ,
    output logic [NIN-1:0]           S_ALLOC,
    input  logic [NIN-1:0]           S_VALID,
    output logic [NIN-1:0]           S_READY,
    input  logic [NIN*DW-1:0]        S_DATA,
    input  logic [NIN*WBITS-1:0]     S_BYTES,
    input  logic [NIN-1:0]           S_LAST,
    input  logic [NIN-1:0]           S_ABORT,
    output logic                     M_VALID,
    input  logic                     M_READY,
    output logic [DW-1:0]            M_DATA,
    output logic [WBITS-1:0]         M_BYTES,
    output logic                     M_LAST,
    output logic                     M_ABORT,
    output logic [$clog2(NIN)-1:0]   o_grant_idx,
    output logic [31:0]              o_debug
);
    localparam int IW = $clog2(NIN);
    state_t           state_q;
    logic [NIN-1:0]   alloc_q;
    logic [IW-1:0]    ptr_q, gidx_q;
    logic             midpkt_q, mvalid_q, mlast_q, mabort_q;
    logic [DW-1:0]    mdata_q;
    logic [WBITS-1:0] mbytes_q;
    logic [DW-1:0]    sdata [NIN];
    logic [WBITS-1:0] sbytes [NIN];
    logic [NIN-1:0]   win_oh;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic             out_free, ready_g, sv, sl, sa, sc, accept, midpkt_d;
    for (genvar i = 0; i < NIN; i++) begin : g_unpack
        assign sdata[i]  = S_DATA[i*DW +: DW];
        assign sbytes[i] = S_BYTES[i*WBITS +: WBITS];
    end
    axin_rrpick #(.N(NIN)) u_pick (
        .req_i    (S_CHREQ),
        .ptr_i    (ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );
    always_comb begin
        out_free = !mvalid_q || M_READY;
        ready_g  = (state_q == GRANT) && out_free && !mabort_q && i_cfg_active;
        sv       = S_VALID[gidx_q];
        sl       = S_LAST[gidx_q];
        sa       = S_ABORT[gidx_q];
        sc       = S_CHREQ[gidx_q];
        accept   = sv && ready_g && !sa;
        midpkt_d = accept ? !sl : midpkt_q;
    end
    assign S_ALLOC     = alloc_q;
    assign S_READY     = ready_g ? alloc_q : '0;
    assign M_VALID     = mvalid_q;
    assign M_DATA      = mdata_q;
    assign M_BYTES     = mbytes_q;
    assign M_LAST      = mlast_q;
    assign M_ABORT     = mabort_q;
    assign o_grant_idx = gidx_q;
    always_comb begin
        o_debug                    = '0;
        o_debug[DBG_STATE]         = state_q;
        o_debug[DBG_ALLOC +: NIN]  = alloc_q;
        o_debug[DBG_FLAGS +: 5]    = {midpkt_q, mabort_q, mlast_q, M_READY, mvalid_q};
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            alloc_q  <= '0;
            ptr_q    <= '0;
            gidx_q   <= '0;
            midpkt_q <= 1'b0;
            mvalid_q <= 1'b0;
            mabort_q <= 1'b0;
            mdata_q  <= '0;
            mbytes_q <= '0;
            mlast_q  <= 1'b0;
        end else begin
            // Output stage advances whenever the egress slot is free; an abort is seen on that edge.
            if (out_free) begin
                mvalid_q <= accept;
                mabort_q <= 1'b0;
                if (accept) begin
                    mdata_q  <= sdata[gidx_q];
                    mbytes_q <= sbytes[gidx_q];
                    mlast_q  <= sl;
                end else if (OPT_LOWPOWER) begin
                    mdata_q  <= '0;
                    mbytes_q <= '0;
                    mlast_q  <= 1'b0;
                end
            end
            if (state_q == IDLE) begin
                if (i_cfg_active && win_any) begin
                    state_q <= GRANT;
                    alloc_q <= win_oh;
                    gidx_q  <= win_idx;
                    ptr_q   <= (win_idx == IW'(NIN - 1)) ? '0 : win_idx + IW'(1);
                end
            end else if (!i_cfg_active) begin
                state_q  <= IDLE;
                alloc_q  <= '0;
                midpkt_q <= 1'b0;
                mvalid_q <= 1'b0;
                mabort_q <= midpkt_q || (mabort_q && !out_free);
                if (OPT_LOWPOWER) begin
                    mdata_q  <= '0;
                    mbytes_q <= '0;
                    mlast_q  <= 1'b0;
                end
            end else if (sa && (!sv || ready_g)) begin
                state_q  <= IDLE;
                alloc_q  <= '0;
                midpkt_q <= 1'b0;
                if (midpkt_q) mabort_q <= !mvalid_q || !mlast_q;
            end else if (accept && sl) begin
                state_q  <= IDLE;
                alloc_q  <= '0;
                midpkt_q <= 1'b0;
            end else if (!sc) begin
                // Withdrawal: abort only if part of a packet has gone out.
                state_q  <= IDLE;
                alloc_q  <= '0;
                midpkt_q <= 1'b0;
                if (midpkt_d) mabort_q <= 1'b1;
            end else begin
                midpkt_q <= midpkt_d;
            end
        end
    end
endmodule

// File: tb/tb_axin_challoc.sv
// tb_axin_challoc: vector table, hand sequences and randomized scoreboard check of axin_challoc.
module tb_axin_challoc;
    localparam int NIN = 4;
    localparam int DW  = 64;
    localparam int WB  = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg = 1'b0;
    logic [NIN-1:0] chreq = '0, svalid = '0, slast = '0, sabort = '0;
    logic [NIN*DW-1:0] sdata = '0;
    logic [NIN*WB-1:0] sbytes = '0;
    logic mready = 1'b0;
    logic [NIN-1:0] S_ALLOC, S_READY;
    logic M_VALID, M_LAST, M_ABORT;
    logic [DW-1:0] M_DATA;
    logic [WB-1:0] M_BYTES;
    logic [1:0] o_grant_idx;
    logic [31:0] o_debug;
    int nvec = 0;
    int nerr = 0;
    always #5 clk = ~clk;
    axin_challoc #(.NIN(NIN), .DW(DW), .WBITS(WB), .OPT_LOWPOWER(1'b0)) dut (
        .i_clk(clk), .i_reset(rst), .i_cfg_active(cfg),
        .S_CHREQ(chreq), .S_ALLOC(S_ALLOC), .S_VALID(svalid), .S_READY(S_READY),
        .S_DATA(sdata), .S_BYTES(sbytes), .S_LAST(slast), .S_ABORT(sabort),
        .M_VALID(M_VALID), .M_READY(mready), .M_DATA(M_DATA), .M_BYTES(M_BYTES),
        .M_LAST(M_LAST), .M_ABORT(M_ABORT), .o_grant_idx(o_grant_idx), .o_debug(o_debug)
    );
    typedef struct {
        logic cfg; logic [3:0] req, vld, lst, abt; logic rdy; logic [63:0] d;
        logic [3:0] ea, er; logic emv, eml, ema; logic [63:0] emd;
    } vec_t;
    typedef struct { logic [63:0] d; logic [WB-1:0] b; logic l; } beat_t;
    vec_t  tbl[$];
    beat_t q[$];
    int    plen[NIN], sent[NIN];
    int    exp_ptr, pend_win;
    logic  pend;
    logic [NIN-1:0] exp_alloc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; cfg = 1'b0; chreq = '0; svalid = '0; slast = '0; sabort = '0; mready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle of the random scoreboard run; drain stops new requests and lets the owner finish.
    task automatic rnd_cycle(input logic drain);
        logic rel;
        beat_t b;
        tick();
        chk("rnd_alloc", S_ALLOC, exp_alloc);
        if (pend) begin
            chk("rnd_gidx", o_grant_idx, pend_win);
            pend = 1'b0;
        end
        chk("rnd_abort", M_ABORT, 0);
        for (int i = 0; i < NIN; i++) begin
            if (S_ALLOC[i]) begin
                chreq[i]  = 1'b1;
                svalid[i] = drain ? 1'b1 : ($urandom % 4) != 0;
                slast[i]  = sent[i] == plen[i] - 1;
            end else begin
                if (drain) chreq[i] = 1'b0;
                else if ($urandom % 4 == 0) chreq[i] = ~chreq[i];
                svalid[i] = drain ? 1'b0 : 1'($urandom % 2);
                slast[i]  = 1'($urandom % 2);
            end
            sdata[i*DW +: DW] = {$urandom, $urandom};
            sbytes[i*WB +: WB] = WB'($urandom);
        end
        mready = drain ? 1'b1 : ($urandom % 3) != 0;
        #2;
        chk("rnd_sready", S_READY, (!M_VALID || mready) ? S_ALLOC : 4'b0);
        if (M_VALID && mready) begin
            if (q.size() == 0) chk("rnd_extra_beat", 1, 0);
            else begin
                b = q.pop_front();
                chk("rnd_mdata", M_DATA, b.d);
                chk("rnd_mbytes", M_BYTES, b.b);
                chk("rnd_mlast", M_LAST, b.l);
            end
        end
        rel = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            if (svalid[i] && S_READY[i]) begin
                q.push_back('{sdata[i*DW +: DW], sbytes[i*WB +: WB], slast[i]});
                if (slast[i]) begin
                    rel = 1'b1;
                    sent[i] = 0;
                    plen[i] = 1 + int'($urandom % 4);
                end else sent[i]++;
            end
        end
        if (S_ALLOC == 0 && chreq != 0) begin
            pend_win = -1;
            for (int k = 0; k < NIN; k++) begin
                if (pend_win < 0 && chreq[(exp_ptr + k) % NIN]) pend_win = (exp_ptr + k) % NIN;
            end
            pend      = 1'b1;
            exp_ptr   = (pend_win + 1) % NIN;
            exp_alloc = NIN'(1) << pend_win;
        end else exp_alloc = rel ? '0 : S_ALLOC;
    endtask

    initial begin
        tbl.push_back('{1'b1,4'b0010,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b0010,4'b0010,4'b0000,4'b0000,1'b1,64'hD0, 4'b0010,4'b0010,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b0010,4'b0010,4'b0000,4'b0000,1'b1,64'hD1, 4'b0010,4'b0010,1'b1,1'b0,1'b0,64'hD0});
        tbl.push_back('{1'b1,4'b0010,4'b0010,4'b0010,4'b0000,1'b1,64'hD2, 4'b0010,4'b0010,1'b1,1'b0,1'b0,64'hD1});
        tbl.push_back('{1'b1,4'b0010,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b1,1'b1,1'b0,64'hD2});
        tbl.push_back('{1'b1,4'b0010,4'b0010,4'b0000,4'b0000,1'b0,64'hD3, 4'b0010,4'b0010,1'b0,1'b0,1'b0,64'h0});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1'b1,4'b0010,4'b0010,4'b0000,4'b0000,1'b0,64'hD4, 4'b0010,4'b0000,1'b1,1'b0,1'b0,64'hD3});
        tbl.push_back('{1'b1,4'b0010,4'b0010,4'b0000,4'b0000,1'b1,64'hD4, 4'b0010,4'b0010,1'b1,1'b0,1'b0,64'hD3});
        tbl.push_back('{1'b1,4'b0010,4'b0010,4'b0000,4'b0000,1'b1,64'hD5, 4'b0010,4'b0010,1'b1,1'b0,1'b0,64'hD4});
        tbl.push_back('{1'b1,4'b0010,4'b0000,4'b0000,4'b0010,1'b1,64'h0,  4'b0010,4'b0010,1'b1,1'b0,1'b0,64'hD5});
        tbl.push_back('{1'b1,4'b0100,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b1,64'h0});
        tbl.push_back('{1'b1,4'b0100,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0100,4'b0100,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0100,4'b0100,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b1000,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b1000,4'b1000,4'b0000,4'b0000,1'b1,64'hD6, 4'b1000,4'b1000,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b0,4'b1000,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b1000,4'b0000,1'b1,1'b0,1'b0,64'hD6});
        tbl.push_back('{1'b0,4'b0000,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b1,64'h0});
        tbl.push_back('{1'b0,4'b0001,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b0001,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b0001,4'b0001,4'b0000,4'b0000,1'b1,64'hD7, 4'b0001,4'b0001,1'b0,1'b0,1'b0,64'h0});
        tbl.push_back('{1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0001,4'b0001,1'b1,1'b0,1'b0,64'hD7});
        tbl.push_back('{1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b1,64'h0});
        tbl.push_back('{1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b1,64'h0,  4'b0000,4'b0000,1'b0,1'b0,1'b0,64'h0});

        reset_dut();
        chk("rst_alloc", S_ALLOC, 0);
        chk("rst_mvalid", M_VALID, 0);
        chk("rst_mabort", M_ABORT, 0);
        chk("rst_mdata", M_DATA, 0);
        chk("rst_mbytes", M_BYTES, 0);
        chk("rst_mlast", M_LAST, 0);
        chk("rst_gidx", o_grant_idx, 0);
        chk("rst_dbg_state", o_debug[0], 0);

        foreach (tbl[k]) begin
            tick();
            cfg = tbl[k].cfg; chreq = tbl[k].req; svalid = tbl[k].vld; slast = tbl[k].lst;
            sabort = tbl[k].abt; mready = tbl[k].rdy; sdata = {NIN{tbl[k].d}}; sbytes = {NIN{3'd5}};
            #2;
            chk($sformatf("r%0d_alloc", k), S_ALLOC, tbl[k].ea);
            chk($sformatf("r%0d_sready", k), S_READY, tbl[k].er);
            chk($sformatf("r%0d_mvalid", k), M_VALID, tbl[k].emv);
            chk($sformatf("r%0d_mabort", k), M_ABORT, tbl[k].ema);
            if (tbl[k].emv) begin
                chk($sformatf("r%0d_mdata", k), M_DATA, tbl[k].emd);
                chk($sformatf("r%0d_mlast", k), M_LAST, tbl[k].eml);
            end
        end

        // Fairness: everyone requests, one-beat packets, expect 0,1,2,3,0 with idle gaps.
        reset_dut();
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            int n = 0;
            logic [NIN-1:0] prev = '0;
            cfg = 1'b1; chreq = 4'b1111; mready = 1'b1;
            for (int c = 0; c < 100 && n < 5; c++) begin
                tick();
                if (S_ALLOC != 0) begin
                    chk("fair_gap", prev, 0);
                    chk($sformatf("fair_grant%0d", n), S_ALLOC, NIN'(1) << order[n]);
                    chk($sformatf("fair_idx%0d", n), o_grant_idx, order[n]);
                    n++;
                end
                svalid = S_ALLOC; slast = S_ALLOC;
                prev = S_ALLOC;
            end
            if (n < 5) chk("fair_timeout", n, 5);
            svalid = '0; slast = '0; chreq = '0;
        end

        // Randomized traffic against a packet-level scoreboard.
        reset_dut();
        cfg = 1'b1; exp_ptr = 0; exp_alloc = '0; pend = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            plen[i] = 1 + int'($urandom % 4);
            sent[i] = 0;
        end
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b0);
        for (int c = 0; c < 40; c++) rnd_cycle(1'b1);
        chk("rnd_drain", q.size(), 0);

        // Async reset mid-packet clears outputs before any clock edge.
        reset_dut();
        cfg = 1'b1; chreq = 4'b0001; mready = 1'b1;
        begin
            int c = 0;
            while (S_ALLOC != 4'b0001 && c < 10) begin tick(); c++; end
            chk("arst_granted", S_ALLOC, 4'b0001);
        end
        svalid = 4'b0001; slast = 4'b0000; sdata = {NIN{64'hABCD}};
        tick();
        svalid = '0;
        #2;
        chk("arst_pre_mvalid", M_VALID, 1);
        rst = 1'b1;
        #1;
        chk("arst_alloc", S_ALLOC, 0);
        chk("arst_mvalid", M_VALID, 0);
        chk("arst_mabort", M_ABORT, 0);
        tick();
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/axin_challoc.md
Name: axin_challoc

Overview:
- Per-output-port channel allocator and stream multiplexer: one instance sits in front of each egress port.
- Accepts CHREQ/ALLOC channel requests from NIN broadcast units and grants the port to one requester at a time, round-robin.
- Forwards the granted requester's packet stream through a registered output stage.
- Releases the port on end of packet, requester withdrawal (deadlock back-off) or port deactivation, and emits ABORT if a packet is cut short.

Parameters:
- NIN, 4, number of requesting broadcast units.
- DW, 64, data bits per beat.
- WBITS, $clog2(DW/8), width of BYTES field.
- OPT_LOWPOWER, 0, when 1, M_DATA/M_BYTES/M_LAST are zero whenever M_VALID is low.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_cfg_active  in  1  egress port enabled.
- S_CHREQ  in  NIN  channel request per requester.
- S_ALLOC  out  NIN  one-hot (or zero) channel grant.
- S_VALID  in  NIN  per-requester beat valid.
- S_READY  out  NIN  per-requester beat ready.
- S_DATA  in  NIN*DW  per-requester data.
- S_BYTES  in  NIN*WBITS  per-requester byte count.
- S_LAST  in  NIN  per-requester last beat.
- S_ABORT  in  NIN  per-requester packet abort.
- M_VALID  out  1  egress beat valid.
- M_READY  in  1  egress ready.
- M_DATA  out  DW  egress data.
- M_BYTES  out  WBITS  egress byte count.
- M_LAST  out  1  egress last beat.
- M_ABORT  out  1  egress abort.
- o_grant_idx  out  $clog2(NIN)  index of current or most recent winner.
- o_debug  out  32  state, S_ALLOC, M_VALID/M_READY/M_LAST/M_ABORT, midpkt.

Behaviour:
- Reset (async): state=IDLE, S_ALLOC=0, M_VALID=0, M_ABORT=0, M_DATA/M_BYTES/M_LAST=0, priority pointer=0, o_grant_idx=0, midpkt=0.
- IDLE state:
  - If i_cfg_active and (S_CHREQ != 0): pick the first set requester at or after the pointer (wrapping modulo NIN).
  - Next cycle: S_ALLOC=onehot(winner), pointer=winner+1 mod NIN, o_grant_idx=winner, state=GRANT.
  - Grant latency is exactly one cycle from the request being seen.
- GRANT state:
  - S_READY[g] = (!M_VALID || M_READY) && !M_ABORT && i_cfg_active. S_READY is 0 for every non-granted requester.
  - Accepted beat (S_VALID[g]&&S_READY[g]&&!S_ABORT[g]) loads M_* on the next edge; one-cycle latency.
  - M_* hold while M_VALID && !M_READY.
  - midpkt is set on an accepted non-LAST beat and cleared on an accepted LAST beat.
- Release conditions, in priority order. Each one forces state=IDLE and S_ALLOC=0 on the next edge:
  - (a) !i_cfg_active: M_VALID<=0, and M_ABORT<=1 if midpkt.
  - (b) S_ABORT[g] && (!S_VALID[g] || S_READY[g]): if midpkt, M_ABORT<=(!M_VALID || !M_LAST); otherwise silent drop.
  - (c) Accepted LAST beat: normal release.
  - (d) S_CHREQ[g] low: if midpkt, M_ABORT<=1 (withdrawal mid-packet); if no beat was forwarded, silent release (deadlock back-off).
- After any release, S_ALLOC=0 for at least one cycle before the next grant.
- M_ABORT clears on the first edge with (!M_VALID || M_READY) after it was set. No new beat is loaded while M_ABORT is high. midpkt clears when M_ABORT is set.
- CHREQ asserted in the same cycle as a release is not considered until IDLE. The pointer has already advanced, so the releasing requester has lowest priority.
- Reset mid-packet: all outputs go to their reset values immediately. No ABORT is emitted.
- OPT_LOWPOWER: when M_VALID is cleared, or a cycle has no accepted beat, zero M_DATA/M_BYTES/M_LAST.

Decomposition:
- Shared package: AXIN beat field widths (DW, WBITS), and state encodings IDLE=1'b0, GRANT=1'b1 with their o_debug bit positions.
- One natural sub-module: axin_rrpick. It is combinational round-robin: (request vector, pointer) -> one-hot winner, index and any-valid. It is reusable by other switch arbiters.

Test Plan:
- Single packet: S_CHREQ=4'b0010, 3-beat packet D0,D1,D2 (LAST on D2), M_READY=1.
  -> S_ALLOC=4'b0010 one cycle later; M_DATA=D0,D1,D2 each one cycle after acceptance; M_LAST with D2; S_ALLOC=0 the cycle after D2 is accepted.
- Fairness: S_CHREQ=4'b1111 held, 1-beat packets, pointer=0.
  -> grant order 0,1,2,3,0; S_ALLOC=0 for at least one cycle between grants.
- Backpressure: M_READY=0 for 5 cycles mid-packet.
  -> M_DATA/M_LAST stable, S_READY[g]=0; no beat lost or duplicated when M_READY returns.
- Abort: S_ABORT[g] after 2 forwarded beats.
  -> M_ABORT=1 for one cycle (M_READY=1); S_ALLOC=0; next requester granted after the idle cycle.
- Withdrawal and deactivation:
  - S_CHREQ[g] drops before any beat -> silent release, M_ABORT stays 0.
  - i_cfg_active drops mid-packet -> M_VALID=0, M_ABORT=1, grant released.
- Async reset asserted mid-packet -> S_ALLOC=0, M_VALID=0, M_ABORT=0 without waiting for a clock edge.
